// File: rtl/bool_lut_eval.sv
// -----------------------------------------------------------------------------
// bool_lut_eval
//   Run-time programmable evaluator for N_OUT boolean functions of N_IN inputs.
//   A 2**N_IN x N_OUT truth table is loaded through a valid/ready config port
//   and looked up with a registered (latency 1) output.
//
//   Optional feature macro: BOOL_LUT_PARITY_EN
//     defined   : beats with bad even parity are rejected and flag o_cfg_err
//     undefined : i_cfg_par is ignored, o_cfg_err is tied low
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous reset, active low
//   i_cfg_start  pulse: (re)start a full table load at entry 0
//   i_cfg_valid  config beat valid
//   o_cfg_ready  high while loading
//   i_cfg_data   table entry, bit k = function k at the current minterm
//   i_cfg_par    even parity over i_cfg_data (parity build only)
//   o_cfg_done   one-cycle pulse after the last entry is written
//   o_cfg_err    sticky parity error (parity build only)
//   i_x_valid    evaluate i_x this cycle
//   i_x          input vector, MSB = input A
//   o_y_valid    o_y holds a fresh result
//   o_y          registered table[i_x]
// -----------------------------------------------------------------------------
module bool_lut_eval #(
   parameter int unsigned N_IN  = 5,
   parameter int unsigned N_OUT = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cfg_start,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [N_OUT-1:0] i_cfg_data,
   input  logic             i_cfg_par,
   output logic             o_cfg_done,
   output logic             o_cfg_err,
   input  logic             i_x_valid,
   input  logic [N_IN-1:0]  i_x,
   output logic             o_y_valid,
   output logic [N_OUT-1:0] o_y
);

   localparam int unsigned     DEPTH     = 2 ** N_IN;
   localparam logic [N_IN-1:0] LAST_ADDR = {N_IN{1'b1}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [N_IN-1:0]  r_addr;
   logic [N_IN-1:0]  w_addr_nxt;
   logic [N_OUT-1:0] r_table [DEPTH];
   logic             r_cfg_done;
   logic             r_y_valid;
   logic [N_OUT-1:0] r_y;

   logic w_par_ok;
   logic w_hs;
   logic w_write;
   logic w_last;
   logic w_eval;

`ifdef BOOL_LUT_PARITY_EN
   logic r_cfg_err;
   assign w_par_ok = (i_cfg_par == ^i_cfg_data);
`else
   logic w_unused_par;
   assign w_unused_par = i_cfg_par;
   assign w_par_ok     = 1'b1;
`endif

   assign o_cfg_ready = (r_state == ST_LOAD);

   // cfg_start wins over a same-cycle beat, so that beat never counts.
   assign w_hs    = i_cfg_valid & o_cfg_ready & ~i_cfg_start;
   assign w_write = w_hs & w_par_ok;
   assign w_last  = w_write & (r_addr == LAST_ADDR);
   // In RUN the lookup uses the current table even if a load starts now.
   assign w_eval  = (r_state == ST_RUN) & i_x_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (i_cfg_start) begin
               w_state_nxt = ST_LOAD;
               w_addr_nxt  = '0;
            end
         end
         ST_LOAD: begin
            if (i_cfg_start) begin
               w_addr_nxt = '0;
            end else if (w_write) begin
               if (w_last) begin
                  w_state_nxt = ST_RUN;
                  w_addr_nxt  = '0;
               end else begin
                  w_addr_nxt = r_addr + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (i_cfg_start) begin
               w_state_nxt = ST_LOAD;
               w_addr_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_addr_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_cfg_done <= 1'b0;
         r_y_valid  <= 1'b0;
         r_y        <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_table[i] <= '0;
         end
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_cfg_done <= w_last;
         r_y_valid  <= w_eval;
         if (w_write) begin
            r_table[r_addr] <= i_cfg_data;
         end
         if (w_eval) begin
            r_y <= r_table[i_x];
         end
      end
   end

`ifdef BOOL_LUT_PARITY_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cfg_err <= 1'b0;
      end else if (i_cfg_start) begin
         r_cfg_err <= 1'b0;
      end else if (w_hs && !w_par_ok) begin
         r_cfg_err <= 1'b1;
      end
   end
   assign o_cfg_err = r_cfg_err;
`else
   assign o_cfg_err = 1'b0;
`endif

   assign o_cfg_done = r_cfg_done;
   assign o_y_valid  = r_y_valid;
   assign o_y        = r_y;

endmodule
